obi_rr_csr_arbiter: RTL and testbench
=====================================

// Module: obi_rr_csr_arbiter
// PURPOSE
//  Round-robin N-to-1 OBI arbiter that shares the safe-CPU wrapper CSR OBI slave between the per-hart data demux outputs.
//  Tracks outstanding transactions in an index FIFO so variable-latency responses return to the issuing hart.
//  Holds its grant decision while a request is stalled, which keeps the OBI request stable until the slave grants it.
//  Sits between the per-hart one-to-N demuxes and the OBI-to-reg bridge feeding the CSR reg mux.
// PARAMETERS
//  NMASTER          3   number of requesting harts (>=2)
//  AW               32  address width
//  DW               32  data width
//  MAX_OUTSTANDING  2   depth of response-routing FIFO (>=1, power of 2)
// PORTS
//  clk_i        in   1              clock
//  rst_i        in   1              synchronous reset, active high
//  m_req_i      in   NMASTER        per-master OBI req
//  m_addr_i     in   NMASTER*AW     per-master address
//  m_we_i       in   NMASTER        per-master write enable
//  m_be_i       in   NMASTER*DW/8   per-master byte enables
//  m_wdata_i    in   NMASTER*DW     per-master write data
//  m_gnt_o      out  NMASTER        per-master grant
//  m_rvalid_o   out  NMASTER        per-master response valid
//  m_rdata_o    out  DW             response data, broadcast to all masters
//  s_req_o      out  1              slave req
//  s_addr_o     out  AW             slave address
//  s_we_o       out  1              slave write enable
//  s_be_o       out  DW/8           slave byte enables
//  s_wdata_o    out  DW             slave write data
//  s_gnt_i      in   1              slave grant
//  s_rvalid_i   in   1              slave response valid
//  s_rdata_i    in   DW             slave response data
//  err_o        out  1              sticky flag: s_rvalid_i arrived while no transaction was outstanding
// BEHAVIOUR
//  Reset (rst_i=1 at a clk_i edge):
//   - state=ARB, rr_ptr=0, FIFO empty, err_o=0.
//   - All other outputs are combinational and read 0 when no master requests.
//  Request path is combinational, with zero added latency:
//   - s_req_o = m_req_i[sel] & ~fifo_full.
//   - s_addr/we/be/wdata are muxed from sel.
//   - m_gnt_o[sel] = s_gnt_i & s_req_o; all other m_gnt_o bits are 0.
//  FSM states:
//   - ARB: sel = first requesting index at or after rr_ptr, wrapping mod NMASTER.
//     - If s_req_o & ~s_gnt_i: latch sel into hold_idx and go to HOLD.
//     - If s_req_o & s_gnt_i: stay in ARB; rr_ptr <= (sel+1) mod NMASTER.
//   - HOLD: sel = hold_idx, and other masters are ignored.
//     - On s_req_o & s_gnt_i: rr_ptr <= (hold_idx+1) mod NMASTER, go to ARB.
//     - If m_req_i[hold_idx] drops (an OBI protocol violation): return to ARB with no grant issued.
//  Response routing:
//   - On each accepted handshake (s_req_o & s_gnt_i), push sel into the FIFO.
//   - On s_rvalid_i with the FIFO non-empty: pop the head h; m_rvalid_o[h]=1, and every other m_rvalid_o bit is 0, in the same cycle.
//   - m_rdata_o = s_rdata_i always.
//  FIFO boundaries:
//   - Full: s_req_o is forced to 0 and no grant is issued. This holds even if a pop occurs in the same cycle, so there is no full-bypass.
//   - Push and pop in the same cycle when neither full nor empty: occupancy is unchanged and the order is preserved.
//   - Empty with s_rvalid_i=1: all m_rvalid_o stay 0 and err_o sets to 1, held until reset.
//   - Pointers wrap mod MAX_OUTSTANDING; the count is $clog2(MAX_OUTSTANDING)+1 bits wide.
//  Same-cycle response and grant:
//   - A response may pop the FIFO in the same cycle as a new grant pushes it.
//   - The pop always refers to an older entry.
//  Reset mid-transaction:
//   - All in-flight routing is discarded.
//   - Late s_rvalid_i after reset sets err_o.
//  No master is granted twice consecutively while any other master is requesting. Starvation is bounded by NMASTER grants.
// TESTING
//  1. Masters 0,1,2 request continuously, s_gnt_i=1, 1-cycle rvalid -> grants cycle 0,1,2,0,1,2; each hart's rvalid matches its issue order.
//  2. Master 1 alone, s_gnt_i low for 3 cycles; master 2 raises req in cycle 1 -> s_addr_o stays master 1's addr; m_gnt_o=3'b010 on cycle 3; master 2 is granted next.
//  3. MAX_OUTSTANDING=2, s_gnt_i=1, rvalid withheld -> 2 grants, then s_req_o=0; first rvalid (rdata=0xDEADBEEF) routes to the first issuer; the next grant occurs the cycle after.
//  4. FIFO holds 1 entry (master 2); in one cycle rvalid=1 and master 0 is granted -> m_rvalid_o=3'b100; FIFO then holds {0}.
//  5. s_rvalid_i=1 with FIFO empty -> m_rvalid_o=0, err_o=1 next cycle and held until rst_i.
//  6. rst_i asserted in HOLD with 1 entry outstanding -> next cycle state=ARB, rr_ptr=0, FIFO empty, err_o=0; master 0 wins a 3-way tie.

Source files
------------

// File: rtl/obi_rr_csr_arbiter.sv
// Round-robin N-to-1 OBI arbiter in front of the CSR slave. Grants are held while stalled,
// and an index FIFO routes each response back to the hart that issued the request.
module obi_rr_csr_arbiter #(
  parameter int unsigned NMASTER         = 3,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NMASTER-1:0]      m_req_i,
  input  logic [NMASTER*AW-1:0]   m_addr_i,
  input  logic [NMASTER-1:0]      m_we_i,
  input  logic [NMASTER*DW/8-1:0] m_be_i,
  input  logic [NMASTER*DW-1:0]   m_wdata_i,
  output logic [NMASTER-1:0]      m_gnt_o,
  output logic [NMASTER-1:0]      m_rvalid_o,
  output logic [DW-1:0]           m_rdata_o,
  output logic                    s_req_o,
  output logic [AW-1:0]           s_addr_o,
  output logic                    s_we_o,
  output logic [DW/8-1:0]         s_be_o,
  output logic [DW-1:0]           s_wdata_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DW-1:0]           s_rdata_i,
  output logic                    err_o
);

  localparam int unsigned IdxW = $clog2(NMASTER);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned BW   = DW / 8;

  typedef enum logic [0:0] {StArb, StHold} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     hold_idx_q, hold_idx_d;
  logic [IdxW-1:0]     fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [IdxW-1:0]     arb_idx;
  logic                arb_found;
  logic [IdxW-1:0]     sel;
  logic [IdxW-1:0]     sel_next;
  logic                sel_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    return IdxW'(s % NMASTER);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping; falls back to rr_ptr when idle.
  always_comb begin
    arb_idx   = rr_ptr_q;
    arb_found = 1'b0;
    for (int unsigned i = 0; i < NMASTER; i++) begin
      if (!arb_found && m_req_i[wrap_add(rr_ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign sel        = (state_q == StHold) ? hold_idx_q : arb_idx;
  assign sel_next   = wrap_add(sel, 1);
  assign sel_req    = m_req_i[sel];
  assign fifo_full  = (cnt_q == CntW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);

  // No full-bypass: a same-cycle pop does not free a slot for this cycle's request.
  assign s_req_o = sel_req & ~fifo_full;
  assign push    = s_req_o & s_gnt_i;
  assign pop     = s_rvalid_i & ~fifo_empty;

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (sel_req) begin
      s_addr_o  = m_addr_i[32'(sel)*AW +: AW];
      s_we_o    = m_we_i[sel];
      s_be_o    = m_be_i[32'(sel)*BW +: BW];
      s_wdata_o = m_wdata_i[32'(sel)*DW +: DW];
    end
  end

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (push) begin
      m_gnt_o[sel] = 1'b1;
    end
    if (pop) begin
      m_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
    end
  end

  assign m_rdata_o = s_rdata_i;
  assign err_o     = err_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_idx_d = hold_idx_q;
    case (state_q)
      StArb: begin
        if (s_req_o) begin
          if (s_gnt_i) begin
            rr_ptr_d = sel_next;
          end else begin
            hold_idx_d = sel;
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        // A dropped request is a protocol violation; re-arbitrate without granting.
        if (!sel_req) begin
          state_d = StArb;
        end else if (push) begin
          rr_ptr_d = sel_next;
          state_d  = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (s_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StArb;
      rr_ptr_q   <= '0;
      hold_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_idx_q <= hold_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Entries are only read while counted, so the storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_obi_rr_csr_arbiter.sv
// Directed bench for obi_rr_csr_arbiter: a cycle-by-cycle vector table plus short
// hand-written sequences for fairness and stalled-grant completion.
module tb_obi_rr_csr_arbiter;

  localparam int unsigned NM = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_req;
  logic [95:0] m_addr;
  logic [2:0]  m_we;
  logic [11:0] m_be;
  logic [95:0] m_wdata;
  logic [2:0]  m_gnt;
  logic [2:0]  m_rvalid;
  logic [31:0] m_rdata;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic        s_gnt;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic        err;

  always #5 clk = ~clk;

  obi_rr_csr_arbiter #(
    .NMASTER(NM), .AW(32), .DW(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .err_o(err)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [2:0]  egnt;
    logic [2:0]  erv;
    logic        esreq;
    int          esel;   // -1: slave-side payload expected to read 0
    logic        eerr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [31:0] addr_of(int s);
    return (s < 0) ? 32'h0 : 32'h100 + 32'(4 * s);
  endfunction
  function automatic logic [31:0] wdata_of(int s);
    return (s < 0) ? 32'h0 : 32'hA000_0000 + 32'(s);
  endfunction
  function automatic logic [31:0] be_of(int s);
    return (s < 0) ? 32'h0 : 32'(1) << s;
  endfunction
  function automatic logic [31:0] we_of(int s);
    return (s == 1) ? 32'h1 : 32'h0;
  endfunction

  task automatic add_rd(input logic r, input logic [2:0] q, input logic g, input logic v,
                        input logic [31:0] rd, input logic [2:0] eg, input logic [2:0] ev,
                        input logic es, input int sl, input logic ee);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.rv = v; t.rdata = rd;
    t.egnt = eg; t.erv = ev; t.esreq = es; t.esel = sl; t.eerr = ee;
    vecs.push_back(t);
  endtask

  task automatic add(input logic r, input logic [2:0] q, input logic g, input logic v,
                     input logic [2:0] eg, input logic [2:0] ev, input logic es, input int sl,
                     input logic ee);
    add_rd(r, q, g, v, 32'h5A5A_0000 | 32'(vecs.size()), eg, ev, es, sl, ee);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] q, input logic g, input logic v,
                       input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst = r; m_req = q; s_gnt = g; s_rvalid = v; s_rdata = rd;
  endtask

  initial begin
    m_addr  = {32'h108, 32'h104, 32'h100};
    m_wdata = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    m_be    = {4'h4, 4'h2, 4'h1};
    m_we    = 3'b010;
    rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    @(posedge clk);

    //   rst req     gnt rv  egnt    erv     sreq sel err
    add(1, 3'b000, 0, 0, 3'b000, 3'b000, 0, -1, 0);
    // round robin with 1-cycle responses
    add(0, 3'b111, 1, 0, 3'b001, 3'b000, 1, 0, 0);
    add(0, 3'b111, 1, 1, 3'b010, 3'b001, 1, 1, 0);
    add(0, 3'b111, 1, 1, 3'b100, 3'b010, 1, 2, 0);
    add(0, 3'b111, 1, 1, 3'b001, 3'b100, 1, 0, 0);
    add(0, 3'b111, 1, 1, 3'b010, 3'b001, 1, 1, 0);
    add(0, 3'b111, 1, 1, 3'b100, 3'b010, 1, 2, 0);
    add(0, 3'b000, 0, 1, 3'b000, 3'b100, 0, -1, 0);
    // stalled grant held on master 1 while master 2 joins
    add(0, 3'b010, 0, 0, 3'b000, 3'b000, 1, 1, 0);
    add(0, 3'b110, 0, 0, 3'b000, 3'b000, 1, 1, 0);
    add(0, 3'b110, 0, 0, 3'b000, 3'b000, 1, 1, 0);
    add(0, 3'b110, 1, 0, 3'b010, 3'b000, 1, 1, 0);
    add(0, 3'b110, 1, 1, 3'b100, 3'b010, 1, 2, 0);
    add(0, 3'b000, 0, 1, 3'b000, 3'b100, 0, -1, 0);
    // FIFO fills, request blocked even with a same-cycle pop
    add(0, 3'b111, 1, 0, 3'b001, 3'b000, 1, 0, 0);
    add(0, 3'b111, 1, 0, 3'b010, 3'b000, 1, 1, 0);
    add(0, 3'b111, 1, 0, 3'b000, 3'b000, 0, 2, 0);
    add_rd(0, 3'b111, 1, 1, 32'hDEAD_BEEF, 3'b000, 3'b001, 0, 2, 0);
    add(0, 3'b111, 1, 0, 3'b100, 3'b000, 1, 2, 0);
    // same-cycle pop of master 2 and push of master 0
    add(0, 3'b000, 0, 1, 3'b000, 3'b010, 0, -1, 0);
    add(0, 3'b001, 1, 1, 3'b001, 3'b100, 1, 0, 0);
    add(0, 3'b000, 0, 1, 3'b000, 3'b001, 0, -1, 0);
    // response with nothing outstanding
    add(0, 3'b000, 0, 1, 3'b000, 3'b000, 0, -1, 0);
    add(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, -1, 1);
    add(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, -1, 1);
    // reset while holding master 2 with master 1 outstanding
    add(0, 3'b010, 1, 0, 3'b010, 3'b000, 1, 1, 1);
    add(0, 3'b101, 0, 0, 3'b000, 3'b000, 1, 2, 1);
    add(1, 3'b101, 0, 0, 3'b000, 3'b000, 1, 2, 1);
    add(0, 3'b111, 1, 0, 3'b001, 3'b000, 1, 0, 0);
    add(0, 3'b000, 0, 1, 3'b000, 3'b001, 0, -1, 0);
    add(0, 3'b000, 0, 1, 3'b000, 3'b000, 0, -1, 0);
    add(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, -1, 1);
    // held master drops its request: no grant, others ignored that cycle
    add(1, 3'b000, 0, 0, 3'b000, 3'b000, 0, -1, 1);
    add(0, 3'b001, 0, 0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 3'b110, 1, 0, 3'b000, 3'b000, 0, -1, 0);
    add(0, 3'b110, 1, 0, 3'b010, 3'b000, 1, 1, 0);
    add(0, 3'b000, 0, 1, 3'b000, 3'b010, 0, -1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      @(negedge clk);
      n_vec++;
      chk("m_gnt", i, 32'(m_gnt), 32'(vecs[i].egnt));
      chk("m_rvalid", i, 32'(m_rvalid), 32'(vecs[i].erv));
      chk("s_req", i, 32'(s_req), 32'(vecs[i].esreq));
      chk("s_addr", i, s_addr, addr_of(vecs[i].esel));
      chk("s_wdata", i, s_wdata, wdata_of(vecs[i].esel));
      chk("s_be", i, 32'(s_be), be_of(vecs[i].esel));
      chk("s_we", i, 32'(s_we), we_of(vecs[i].esel));
      chk("m_rdata", i, m_rdata, vecs[i].rdata);
      chk("err", i, 32'(err), 32'(vecs[i].eerr));
    end

    // Saturated fairness: grants rotate 0,1,2 and responses follow one cycle behind.
    drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 3'b111, 1'b1, k > 0, 32'h0);
      @(negedge clk);
      n_vec++;
      chk("fair_gnt", 100 + k, 32'(m_gnt), 32'(1) << (k % NM));
      chk("fair_rvalid", 100 + k, 32'(m_rvalid), (k > 0) ? 32'(1) << ((k - 1) % NM) : 32'h0);
    end

    // Master 2 stalled for a random number of cycles must eventually be granted.
    begin
      int stall;
      int waited;
      bit seen;
      stall = $urandom_range(1, 4);
      drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      seen = 1'b0;
      waited = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        drive(1'b0, 3'b100, c >= stall, 1'b0, 32'h0);
        @(negedge clk);
        if (m_gnt != 3'b000) seen = 1'b1;
        else waited++;
      end
      n_vec++;
      if (!seen) begin
        n_miss++;
        $display("FAIL stall_gnt: no grant within 10 cycles, want grant after %0d", stall);
      end else begin
        chk("stall_gnt", 200, 32'(m_gnt), 32'h4);
        chk("stall_wait", 201, 32'(waited), 32'(stall));
        chk("stall_addr", 202, s_addr, 32'h108);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
